mul_seq_ctrl: RTL and testbench

Iterative shift-add multiplier controller. It sequences a single N-bit adder over N cycles to form a 2N-bit unsigned product, with a start/busy/done handshake. It is the area-cheap sequential alternative to the array multiplier. Upstream ALU control uses it for multi-cycle multiply operations.

---
 rtl/mul_seq_ctrl_if.sv | 22 ++
 rtl/mul_seq_ctrl.sv | 97 +++++++++
 tb/tb_mul_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Start/busy/done handshake bundle for the sequential multiplier.
// master drives operands and start; slave returns status and product.
interface mul_seq_ctrl_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier: one N-bit add per cycle, 2N-bit product.
// Optional MUL_SEQ_EARLY_TERM_EN stops once the remaining multiplier bits are zero.
module mul_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           rst,
  mul_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     sum;
  logic           accept;

`ifdef MUL_SEQ_EARLY_TERM_EN
  logic [N-1:0]   rem;
  logic [CW-1:0]  shamt;
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    accept  = bus.start && (state_q != RUN);
    sum     = {1'b0, acc_q[2*N-1:N]}
            + {1'b0, (acc_q[0] ? mcand_q : {N{1'b0}})};
`ifdef MUL_SEQ_EARLY_TERM_EN
    rem     = acc_q[N-1:0] & ({N{1'b1}} >> cnt_q);
    shamt   = CW'(N) - cnt_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          mcand_d = bus.a;
          acc_d   = {{N{1'b0}}, bus.b};
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // carry of the add lands in the top bit as the register shifts right
        acc_d = {sum, acc_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
`ifdef MUL_SEQ_EARLY_TERM_EN
        if (rem == '0) begin
          acc_d   = acc_q >> shamt;
          state_d = DONE;
        end
`endif
        if (state_d == DONE) begin
          p_d = acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed testbench for mul_seq_ctrl (N=8).
// Expected latencies follow MUL_SEQ_EARLY_TERM_EN when it is defined.
module tb_mul_seq_ctrl;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mul_seq_ctrl_if #(.N(N)) bus ();

  mul_seq_ctrl #(.N(N), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done cycle counted from the accepting edge (edge 0)
  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int k;
    k = -1;
    for (int i = 0; i < N; i++) if (b[i]) k = i;
    if (k < 0) return 2;
    return (k + 3 < N + 1) ? k + 3 : N + 1;
`else
    return N + 1;
`endif
  endfunction

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
  endtask

  // start must already be high; returns the done cycle (0 on timeout)
  task automatic wait_done(input int poke_cyc,
                           output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.done === 1'b1) begin
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        cyc = c;
        return;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (c == poke_cyc) begin
        bus.start = 1'b1;
        bus.a     = 8'd5;
        bus.b     = 8'd5;
      end else begin
        bus.start = 1'b0;
        bus.a     = ~bus.a;
        bus.b     = ~bus.b;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.p !== 16'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b p=%0d, want 0 0 0",
               bus.busy, bus.done, bus.p);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    launch(8'd13, 8'd11);
    wait_done(0, cyc, ok);
    n_checks++;
    if (cyc !== exp_lat(8'd11)) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", cyc, exp_lat(8'd11));
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_busy: busy not high exactly in RUN cycles");
    end
    n_checks++;
    if (bus.p !== 16'd143) begin
      n_fail++;
      $display("FAIL basic_p: got %0d want 143", bus.p);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.p !== 16'd143) begin
      n_fail++;
      $display("FAIL basic_hold: done=%b p=%0d want 0 143", bus.done, bus.p);
    end
  endtask

  task automatic test_extremes();
    logic [N-1:0]   va [4] = '{8'd255, 8'd0,   8'd200, 8'd87};
    logic [N-1:0]   vb [4] = '{8'd255, 8'd200, 8'd0,   8'd3};
    logic [2*N-1:0] vp [4] = '{16'd65025, 16'd0, 16'd0, 16'd261};
    int cyc;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i]);
      wait_done(0, cyc, ok);
      n_checks++;
      if (cyc !== exp_lat(vb[i]) || !ok) begin
        n_fail++;
        $display("FAIL extreme_latency[%0d]: got %0d busy_ok=%b want %0d",
                 i, cyc, ok, exp_lat(vb[i]));
      end
      n_checks++;
      if (bus.p !== vp[i]) begin
        n_fail++;
        $display("FAIL extreme_p[%0d]: got %0d want %0d", i, bus.p, vp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    launch(8'd13, 8'd11);
    wait_done(0, cyc, ok);
    n_checks++;
    if (cyc !== exp_lat(8'd11) || bus.p !== 16'd143) begin
      n_fail++;
      $display("FAIL b2b_first: cyc=%0d p=%0d want %0d 143",
               cyc, bus.p, exp_lat(8'd11));
    end
    bus.start = 1'b1;
    bus.a     = 8'd6;
    bus.b     = 8'd7;
    wait_done(0, cyc, ok);
    n_checks++;
    if (cyc !== exp_lat(8'd7) || !ok) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d busy_ok=%b want %0d",
               cyc, ok, exp_lat(8'd7));
    end
    n_checks++;
    if (bus.p !== 16'd42) begin
      n_fail++;
      $display("FAIL b2b_second_p: got %0d want 42", bus.p);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit ok;
    launch(8'd13, 8'd11);
    wait_done(4, cyc, ok);
    n_checks++;
    if (cyc !== exp_lat(8'd11) || !ok) begin
      n_fail++;
      $display("FAIL ignore_latency: got %0d busy_ok=%b want %0d",
               cyc, ok, exp_lat(8'd11));
    end
    n_checks++;
    if (bus.p !== 16'd143) begin
      n_fail++;
      $display("FAIL ignore_p: got %0d want 143", bus.p);
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit ok;
    launch(8'd200, 8'd201);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.p !== 16'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b p=%0d want 0 0 0",
               bus.busy, bus.done, bus.p);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_idle: busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
    launch(8'd9, 8'd9);
    wait_done(0, cyc, ok);
    n_checks++;
    if (cyc !== exp_lat(8'd9) || !ok || bus.p !== 16'd81) begin
      n_fail++;
      $display("FAIL midrun_restart: cyc=%0d p=%0d want %0d 81",
               cyc, bus.p, exp_lat(8'd9));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
